// File: rtl/mips_defs.sv
// Shared widths and constants for the 16-bit MIPS datapath.
package mips_defs;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 8;
    localparam int RA_W   = 3;
    localparam int OP_W   = 3;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [OP_W-1:0] ALU_SLT = 3'd5;
    localparam logic [OP_W-1:0] ALU_SLL = 3'd6;
    localparam logic [OP_W-1:0] ALU_SRL = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/imm_extend.sv
// Immediate widener: sign- or zero-extends a decoder immediate.
module imm_extend #(
    parameter int IMM_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              sext,
    output logic [DATA_W-1:0] ext
);

    logic fill;

    assign fill = sext & imm[IMM_W-1];
    assign ext  = {{(DATA_W-IMM_W){fill}}, imm};

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with writeback forwarding
// on capture and while stalled.
module id_ex_stage #(
    parameter int DATA_W = mips_defs::DATA_W,
    parameter int IMM_W  = mips_defs::IMM_W,
    parameter int RA_W   = mips_defs::RA_W,
    parameter int OP_W   = mips_defs::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   in_rs,
    input  logic [RA_W-1:0]   in_rt,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_imm_sext,
    input  logic              in_alu_src,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b_reg,
    output logic [DATA_W-1:0] out_b_imm,
    output logic              out_alu_src,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_reg_write
);

    import mips_defs::*;

    stage_state_e state_q, state_d;

    logic              accept;
    logic              hold;
    logic              wb_live;
    logic              fwd_cap_a, fwd_cap_b;
    logic              fwd_hold_a, fwd_hold_b;
    logic [RA_W-1:0]   rs_q, rt_q;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] cap_a, cap_b;
    logic              reg_write_q;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign hold     = out_valid & ~out_ready & ~flush;

    imm_extend #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_imm_extend (
        .imm  (in_imm),
        .sext (in_imm_sext),
        .ext  (imm_ext)
    );

    // r0 is hard-wired zero, so it never forwards and never reads data
    assign wb_live    = wb_en & (wb_rd != '0);
    assign fwd_cap_a  = wb_live & (wb_rd == in_rs);
    assign fwd_cap_b  = wb_live & (wb_rd == in_rt);
    assign fwd_hold_a = wb_live & (wb_rd == rs_q);
    assign fwd_hold_b = wb_live & (wb_rd == rt_q);

    assign cap_a = (in_rs == '0) ? '0 :
                   fwd_cap_a     ? wb_data : in_rs_data;
    assign cap_b = (in_rt == '0) ? '0 :
                   fwd_cap_b     ? wb_data : in_rt_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid     = (state_q == ST_FULL);
        out_reg_write = reg_write_q & (state_q == ST_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q        <= '0;
            rt_q        <= '0;
            out_a       <= '0;
            out_b_reg   <= '0;
            out_b_imm   <= '0;
            out_alu_src <= ALU_SRC_REG;
            out_alu_op  <= '0;
            out_rd      <= '0;
            reg_write_q <= 1'b0;
        end else if (accept) begin
            rs_q        <= in_rs;
            rt_q        <= in_rt;
            out_a       <= cap_a;
            out_b_reg   <= cap_b;
            out_b_imm   <= imm_ext;
            out_alu_src <= in_alu_src;
            out_alu_op  <= in_alu_op;
            out_rd      <= in_rd;
            reg_write_q <= in_reg_write;
        end else if (hold) begin
            if (fwd_hold_a) begin
                out_a <= wb_data;
            end
            if (fwd_hold_b) begin
                out_b_reg <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, corner
// sequences and a randomized run against a register-file model.
module tb_id_ex_stage;

    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs, in_rt;
    logic [15:0] in_rs_data, in_rt_data;
    logic [7:0]  in_imm;
    logic        in_imm_sext, in_alu_src;
    logic [2:0]  in_alu_op, in_rd;
    logic        in_reg_write;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_a, out_b_reg, out_b_imm;
    logic        out_alu_src;
    logic [2:0]  out_alu_op, out_rd;
    logic        out_reg_write;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .in_imm        (in_imm),
        .in_imm_sext   (in_imm_sext),
        .in_alu_src    (in_alu_src),
        .in_alu_op     (in_alu_op),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b_reg     (out_b_reg),
        .out_b_imm     (out_b_imm),
        .out_alu_src   (out_alu_src),
        .out_alu_op    (out_alu_op),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
    );

    typedef struct {
        logic [2:0]  rs, rt;
        logic [15:0] rs_d, rt_d;
        logic [7:0]  imm;
        logic        sext, src;
        logic [2:0]  op, rd;
        logic        rw, wen;
        logic [2:0]  wrd;
        logic [15:0] wd;
        logic [15:0] ea, eb, ei;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_rs        = '0;
        in_rt        = '0;
        in_rs_data   = '0;
        in_rt_data   = '0;
        in_imm       = '0;
        in_imm_sext  = 1'b0;
        in_alu_src   = 1'b0;
        in_alu_op    = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;
        wb_en        = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        flush        = 1'b0;
        out_ready    = 1'b1;
    endtask

    task automatic instr(input logic [2:0] rs, input logic [15:0] rsd,
                         input logic [2:0] rt, input logic [15:0] rtd,
                         input logic [2:0] rd);
        in_valid     = 1'b1;
        in_rs        = rs;
        in_rs_data   = rsd;
        in_rt        = rt;
        in_rt_data   = rtd;
        in_rd        = rd;
        in_reg_write = 1'b1;
        in_imm       = 8'h11;
        in_imm_sext  = 1'b0;
        in_alu_src   = ALU_SRC_REG;
        in_alu_op    = ALU_OR;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] ext_ref(logic [7:0] imm, logic sext);
        int v;
        v = int'(imm);
        if (sext && v >= 128) v = v - 256;
        return v[15:0];
    endfunction

    // random-phase model: architectural register file plus the held slot
    logic [15:0] rf[8];
    logic        m_valid;
    logic [2:0]  m_rs, m_rt, m_rd, m_op;
    logic        m_src, m_rw;
    logic [15:0] m_imm;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{3'd2, 3'd3, 16'h1234, 16'h00FF, 8'hF0, 1, 1, ALU_ADD, 3'd4, 1,
                  0, 3'd0, 16'h0000, 16'h1234, 16'h00FF, 16'hFFF0};
        vt[1] = '{3'd2, 3'd3, 16'h1234, 16'h00FF, 8'hF0, 0, 1, ALU_SUB, 3'd4, 1,
                  0, 3'd0, 16'h0000, 16'h1234, 16'h00FF, 16'h00F0};
        vt[2] = '{3'd2, 3'd3, 16'h1234, 16'h00FF, 8'h7F, 1, 0, ALU_AND, 3'd5, 0,
                  1, 3'd2, 16'hBEEF, 16'hBEEF, 16'h00FF, 16'h007F};
        vt[3] = '{3'd2, 3'd3, 16'h1234, 16'h00FF, 8'h01, 1, 0, ALU_OR, 3'd6, 1,
                  1, 3'd0, 16'hBEEF, 16'h1234, 16'h00FF, 16'h0001};
        vt[4] = '{3'd0, 3'd3, 16'hABCD, 16'h00FF, 8'h02, 0, 1, ALU_XOR, 3'd7, 1,
                  1, 3'd0, 16'hBEEF, 16'h0000, 16'h00FF, 16'h0002};
        vt[5] = '{3'd1, 3'd5, 16'h2222, 16'h1111, 8'h80, 1, 1, ALU_SLT, 3'd1, 1,
                  1, 3'd5, 16'hCAFE, 16'h2222, 16'hCAFE, 16'hFF80};
        vt[6] = '{3'd1, 3'd0, 16'h2222, 16'hFFFF, 8'h80, 0, 0, ALU_SLL, 3'd2, 0,
                  0, 3'd0, 16'h0000, 16'h2222, 16'h0000, 16'h0080};
        vt[7] = '{3'd7, 3'd7, 16'h9999, 16'h9999, 8'h00, 1, 1, ALU_SRL, 3'd3, 1,
                  1, 3'd7, 16'h0001, 16'h0001, 16'h0001, 16'h0000};

        // reset state
        idle();
        reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_a", out_a, 0);
        chk("rst_rw", out_reg_write, 0);
        #12;
        reset = 1'b0;
        tick();
        tick();
        chk("idle_valid", out_valid, 0);

        // vector table: back-to-back accepts with out_ready=1
        for (int i = 0; i < 8; i++) begin
            in_valid     = 1'b1;
            in_rs        = vt[i].rs;
            in_rt        = vt[i].rt;
            in_rs_data   = vt[i].rs_d;
            in_rt_data   = vt[i].rt_d;
            in_imm       = vt[i].imm;
            in_imm_sext  = vt[i].sext;
            in_alu_src   = vt[i].src;
            in_alu_op    = vt[i].op;
            in_rd        = vt[i].rd;
            in_reg_write = vt[i].rw;
            wb_en        = vt[i].wen;
            wb_rd        = vt[i].wrd;
            wb_data      = vt[i].wd;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_a", i), out_a, vt[i].ea);
            chk($sformatf("v%0d_b_reg", i), out_b_reg, vt[i].eb);
            chk($sformatf("v%0d_b_imm", i), out_b_imm, vt[i].ei);
            chk($sformatf("v%0d_src", i), out_alu_src, vt[i].src);
            chk($sformatf("v%0d_op", i), out_alu_op, vt[i].op);
            chk($sformatf("v%0d_rd", i), out_rd, vt[i].rd);
            chk($sformatf("v%0d_rw", i), out_reg_write, vt[i].rw);
        end
        idle();
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_rw", out_reg_write, 0);

        // stall for 3 cycles with a writeback to rt in the 2nd
        instr(3'd2, 16'h1234, 3'd3, 16'h00FF, 3'd4);
        tick();
        instr(3'd5, 16'h7777, 3'd6, 16'h6666, 3'd1);
        out_ready = 1'b0;
        #1;
        chk("hold_in_ready0", in_ready, 0);
        tick();
        chk("hold1_valid", out_valid, 1);
        chk("hold1_b", out_b_reg, 16'h00FF);
        wb_en   = 1'b1;
        wb_rd   = 3'd3;
        wb_data = 16'h5555;
        tick();
        chk("hold2_b_fwd", out_b_reg, 16'h5555);
        chk("hold2_a", out_a, 16'h1234);
        chk("hold2_in_ready", in_ready, 0);
        wb_en = 1'b0;
        tick();
        chk("hold3_b", out_b_reg, 16'h5555);
        chk("hold3_rd", out_rd, 3'd4);
        chk("hold3_valid", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_valid", out_valid, 0);
        tick();
        chk("release_idle", out_valid, 0);

        // stream of four, no bubbles, order kept
        for (int k = 1; k <= 4; k++) begin
            instr(3'(k), 16'(k * 16'h0101), 3'd0, 16'h0, 3'(k));
            tick();
            chk($sformatf("stream%0d_valid", k), out_valid, 1);
            chk($sformatf("stream%0d_rd", k), out_rd, k);
            chk($sformatf("stream%0d_a", k), out_a, k * 16'h0101);
        end
        idle();
        tick();
        chk("stream_end", out_valid, 0);

        // flush while full with a valid incoming instruction
        instr(3'd1, 16'hAAAA, 3'd2, 16'hBBBB, 3'd5);
        tick();
        chk("flush_pre", out_valid, 1);
        instr(3'd3, 16'hCCCC, 3'd4, 16'hDDDD, 3'd6);
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_rw", out_reg_write, 0);
        idle();
        tick();
        chk("flush_dropped", out_valid, 0);
        chk("flush_ready", in_ready, 1);

        // asynchronous reset in the middle of a stall
        instr(3'd1, 16'h4321, 3'd2, 16'h8765, 3'd3);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        chk("mid_pre", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_a", out_a, 0);
        chk("mid_b", out_b_reg, 0);
        chk("mid_imm", out_b_imm, 0);
        chk("mid_rd", out_rd, 0);
        chk("mid_ready", in_ready, 1);
        #10;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_idle", out_valid, 0);

        // randomized run against the register-file model
        do_reset();
        for (int r = 0; r < 8; r++) rf[r] = (r == 0) ? 16'h0 : 16'($urandom);
        m_valid = 1'b0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_op = '0;
        m_src = 1'b0; m_rw = 1'b0; m_imm = '0;
        for (int c = 0; c < 3000; c++) begin
            logic acc;
            in_valid     = ($urandom_range(3) != 0);
            out_ready    = ($urandom_range(2) != 0);
            flush        = ($urandom_range(15) == 0);
            in_rs        = 3'($urandom_range(7));
            in_rt        = 3'($urandom_range(7));
            in_rs_data   = (in_rs == 0) ? 16'($urandom) : rf[in_rs];
            in_rt_data   = (in_rt == 0) ? 16'($urandom) : rf[in_rt];
            in_imm       = 8'($urandom);
            in_imm_sext  = 1'($urandom);
            in_alu_src   = 1'($urandom);
            in_alu_op    = 3'($urandom);
            in_rd        = 3'($urandom);
            in_reg_write = 1'($urandom);
            wb_en        = 1'($urandom);
            wb_rd        = 3'($urandom_range(7));
            wb_data      = 16'($urandom);
            #1;
            chk("rnd_in_ready", in_ready, !m_valid || out_ready);
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_rs    = in_rs;
                m_rt    = in_rt;
                m_rd    = in_rd;
                m_op    = in_alu_op;
                m_src   = in_alu_src;
                m_rw    = in_reg_write;
                m_imm   = ext_ref(in_imm, in_imm_sext);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 0) rf[wb_rd] = wb_data;
            tick();
            chk("rnd_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_a", out_a, rf[m_rs]);
                chk("rnd_b_reg", out_b_reg, rf[m_rt]);
                chk("rnd_b_imm", out_b_imm, m_imm);
                chk("rnd_src", out_alu_src, m_src);
                chk("rnd_op", out_alu_op, m_op);
                chk("rnd_rd", out_rd, m_rd);
                chk("rnd_rw", out_reg_write, m_rw);
            end else begin
                chk("rnd_rw_empty", out_reg_write, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
